// File: rtl/sega_joy_pkg.sv
// Shared types and constants for the Sega DB9 joystick scanner.
// Button word order, MSB first: {M,X,Y,Z,S,A,C,B,R,L,D,U}, all active-low.
package sega_joy_pkg;

  typedef enum logic [2:0] {
    ST0     = 3'd0,
    ST1     = 3'd1,
    ST2     = 3'd2,
    ST3     = 3'd3,
    ST4     = 3'd4,
    ST5     = 3'd5,
    ST6     = 3'd6,
    ST_IDLE = 3'd7
  } step_e;

  localparam int U = 0;
  localparam int D = 1;
  localparam int L = 2;
  localparam int R = 3;
  localparam int B = 4;
  localparam int C = 5;
  localparam int A = 6;
  localparam int S = 7;
  localparam int Z = 8;
  localparam int Y = 9;
  localparam int X = 10;
  localparam int M = 11;

  // Raw DB9 pin positions inside a joy*_i vector
  localparam int PIN_U  = 0;
  localparam int PIN_D  = 1;
  localparam int PIN_L  = 2;
  localparam int PIN_R  = 3;
  localparam int PIN_P6 = 4;
  localparam int PIN_P9 = 5;

  localparam logic [11:0] JOY_IDLE = 12'hFFF;

  function automatic logic step_select(step_e s);
    return !(s == ST0 || s == ST3 || s == ST5);
  endfunction

endpackage

// File: rtl/sega_joy_tick.sv
// Scan-step prescaler: counts 0..TICK_DIV-1 and flags the last count.
module sega_joy_tick #(
  parameter int TICK_DIV = 704
) (
  input  logic clk_i,
  input  logic res_n_i,
  output logic tick_o
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick_o = (cnt_q == CNT_LAST);
    cnt_d  = tick_o ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/sega_joy_scanner.sv
// Two-port Sega joystick scanner: drives the shared select line through the
// multiplex sequence, classifies each pad and publishes whole frames only.
module sega_joy_scanner
  import sega_joy_pkg::*;
#(
  parameter int TICK_DIV   = 704,
  parameter int IDLE_TICKS = 249
) (
  input  logic        clk_i,
  input  logic        res_n_i,
  input  logic [5:0]  joy1_i,
  input  logic [5:0]  joy2_i,
  output logic        select_o,
  output logic [11:0] joy1_o,
  output logic [11:0] joy2_o,
  output logic        six1_o,
  output logic        six2_o,
  output logic        frame_o
);

  localparam int IW = $clog2(IDLE_TICKS);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TICKS - 1);

  logic tick;

  sega_joy_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk_i  (clk_i),
    .res_n_i(res_n_i),
    .tick_o (tick)
  );

  logic [11:0]       meta_q, meta_d, sync_q, sync_d;
  step_e             state_q, state_d;
  logic [IW-1:0]     idle_q, idle_d;
  logic              select_q, select_d;
  logic [1:0][11:0]  shadow_q, shadow_d;
  logic [1:0]        six_sh_q, six_sh_d;
  logic [1:0][11:0]  out_q, out_d;
  logic [1:0]        six_out_q, six_out_d;
  logic              frame_q, frame_d;
  logic [5:0]        pins;
  logic [11:0]       word;

  always_comb begin
    meta_d    = {joy2_i, joy1_i};
    sync_d    = meta_q;
    state_d   = state_q;
    idle_d    = idle_q;
    select_d  = select_q;
    shadow_d  = shadow_q;
    six_sh_d  = six_sh_q;
    out_d     = out_q;
    six_out_d = six_out_q;
    frame_d   = 1'b0;
    pins      = '1;
    word      = JOY_IDLE;

    if (tick) begin
      case (state_q)
        ST0:     state_d = ST1;
        ST1:     state_d = ST2;
        ST2:     state_d = ST3;
        ST3:     state_d = ST4;
        ST4:     state_d = ST5;
        ST5:     state_d = ST6;
        ST6: begin
          state_d = ST_IDLE;
          idle_d  = IDLE_LAST;
        end
        ST_IDLE: begin
          if (idle_q == '0) state_d = ST0;
          else              idle_d  = idle_q - 1'b1;
        end
        default: state_d = ST0;
      endcase
      select_d = step_select(state_d);

      // Sampled pins reflect the select level held during the step being left
      for (int p = 0; p < 2; p++) begin
        pins = sync_q[p*6 +: 6];
        word = shadow_q[p];
        case (state_q)
          ST2: begin
            word    = JOY_IDLE;
            word[U] = pins[PIN_U];
            word[D] = pins[PIN_D];
            word[L] = pins[PIN_L];
            word[R] = pins[PIN_R];
            word[B] = pins[PIN_P6];
            word[C] = pins[PIN_P9];
            shadow_d[p] = word;
            six_sh_d[p] = 1'b0;
          end
          ST3: begin
            if (!pins[PIN_R] && !pins[PIN_L]) begin
              word[A] = pins[PIN_P6];
              word[S] = pins[PIN_P9];
            end else begin
              word[B] = pins[PIN_P6];
              word[C] = pins[PIN_P9];
              word[A] = 1'b1;
              word[S] = 1'b1;
            end
            shadow_d[p] = word;
          end
          ST5: begin
            if (pins[3:0] == 4'h0) six_sh_d[p] = 1'b1;
          end
          ST6: begin
            word[Z] = six_sh_q[p] ? pins[PIN_U] : 1'b1;
            word[Y] = six_sh_q[p] ? pins[PIN_D] : 1'b1;
            word[X] = six_sh_q[p] ? pins[PIN_L] : 1'b1;
            word[M] = six_sh_q[p] ? pins[PIN_R] : 1'b1;
            shadow_d[p]  = word;
            out_d[p]     = word;
            six_out_d[p] = six_sh_q[p];
            frame_d      = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      meta_q    <= '1;
      sync_q    <= '1;
      state_q   <= ST0;
      idle_q    <= '0;
      select_q  <= 1'b1;
      shadow_q  <= {JOY_IDLE, JOY_IDLE};
      six_sh_q  <= '0;
      out_q     <= {JOY_IDLE, JOY_IDLE};
      six_out_q <= '0;
      frame_q   <= 1'b0;
    end else begin
      meta_q    <= meta_d;
      sync_q    <= sync_d;
      state_q   <= state_d;
      idle_q    <= idle_d;
      select_q  <= select_d;
      shadow_q  <= shadow_d;
      six_sh_q  <= six_sh_d;
      out_q     <= out_d;
      six_out_q <= six_out_d;
      frame_q   <= frame_d;
    end
  end

  assign select_o = select_q;
  assign joy1_o   = out_q[0];
  assign joy2_o   = out_q[1];
  assign six1_o   = six_out_q[0];
  assign six2_o   = six_out_q[1];
  assign frame_o  = frame_q;

endmodule

// File: tb/tb_sega_joy_scanner.sv
// Directed bench for sega_joy_scanner with a select-driven pad model and a
// queue of expected published frames.
module tb_sega_joy_scanner;

  localparam int TICK_DIV   = 4;
  localparam int IDLE_TICKS = 8;

  localparam int PAD_FLOAT = 0;
  localparam int PAD_SMS   = 1;
  localparam int PAD_MD3   = 2;
  localparam int PAD_MD6   = 3;

  logic        clk_i = 1'b0;
  logic        res_n_i = 1'b0;
  logic [5:0]  joy1_i, joy2_i;
  logic        select_o;
  logic [11:0] joy1_o, joy2_o;
  logic        six1_o, six2_o, frame_o;

  always #5 clk_i = ~clk_i;

  sega_joy_scanner #(.TICK_DIV(TICK_DIV), .IDLE_TICKS(IDLE_TICKS)) dut (
    .clk_i   (clk_i),
    .res_n_i (res_n_i),
    .joy1_i  (joy1_i),
    .joy2_i  (joy2_i),
    .select_o(select_o),
    .joy1_o  (joy1_o),
    .joy2_o  (joy2_o),
    .six1_o  (six1_o),
    .six2_o  (six2_o),
    .frame_o (frame_o)
  );

  // Pad model; held vectors are active-high, in output-word bit order
  int          mode1 = PAD_FLOAT, mode2 = PAD_FLOAT;
  logic [11:0] held1 = '0, held2 = '0;
  int          low_cnt = 0;
  int          high_run = 0;

  always @(posedge clk_i) high_run <= select_o ? high_run + 1 : 0;

  // A 6-button pad counts select-low pulses and rearms after a long high
  always @(negedge select_o) begin
    if (high_run >= 20) low_cnt = 1;
    else                low_cnt = low_cnt + 1;
  end

  function automatic logic [5:0] pad_pins(int mode, logic [11:0] h, logic sel, int cnt);
    case (mode)
      PAD_SMS: return ~{h[5], h[4], h[3:0]};
      PAD_MD3, PAD_MD6: begin
        if (!sel) begin
          if (mode == PAD_MD6 && cnt == 3) return ~{h[7], h[6], 4'b1111};
          return ~{h[7], h[6], 2'b11, h[1], h[0]};
        end
        if (mode == PAD_MD6 && cnt == 3) return ~{h[5], h[4], h[11], h[10], h[9], h[8]};
        return ~{h[5], h[4], h[3:0]};
      end
      default: return 6'h3F;
    endcase
  endfunction

  assign joy1_i = pad_pins(mode1, held1, select_o, low_cnt);
  assign joy2_i = pad_pins(mode2, held2, select_o, low_cnt);

  typedef struct {
    logic [11:0] j1;
    logic [11:0] j2;
    logic        s1;
    logic        s2;
  } exp_t;

  exp_t exp_q[$];
  int   n_assert = 0;
  int   n_fail = 0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push_exp(logic [11:0] j1, logic [11:0] j2, logic s1, logic s2);
    exp_t e;
    e.j1 = j1; e.j2 = j2; e.s1 = s1; e.s2 = s2;
    exp_q.push_back(e);
  endtask

  task automatic wait_frame(output int cycles);
    cycles = -1;
    for (int i = 1; i <= 300; i++) begin
      @(posedge clk_i);
      #1;
      if (frame_o) begin
        cycles = i;
        return;
      end
    end
  endtask

  task automatic check_frame(string tag, output int cycles);
    exp_t e;
    wait_frame(cycles);
    check({tag, "_frame_seen"}, 32'(cycles > 0), 32'd1);
    if (cycles > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_joy1"}, 32'(joy1_o), 32'(e.j1));
      check({tag, "_joy2"}, 32'(joy2_o), 32'(e.j2));
      check({tag, "_six1"}, 32'(six1_o), 32'(e.s1));
      check({tag, "_six2"}, 32'(six2_o), 32'(e.s2));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int falls;
    logic prev_sel;

    // Reset values
    mode1 = PAD_MD3; held1 = 12'h048;      // A and Right
    mode2 = PAD_FLOAT; held2 = '0;
    res_n_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_select", 32'(select_o), 32'd1);
    check("rst_joy1",   32'(joy1_o),   32'hFFF);
    check("rst_joy2",   32'(joy2_o),   32'hFFF);
    check("rst_six1",   32'(six1_o),   32'd0);
    check("rst_six2",   32'(six2_o),   32'd0);
    check("rst_frame",  32'(frame_o),  32'd0);

    // MD 3-button on port 1, first frame latency
    @(negedge clk_i);
    res_n_i = 1'b1;
    push_exp(12'hFB7, 12'hFFF, 1'b0, 1'b0);
    check_frame("md3", cyc);
    check("first_frame_latency", 32'(cyc), 32'd28);

    // Frame period
    push_exp(12'hFB7, 12'hFFF, 1'b0, 1'b0);
    check_frame("md3_again", cyc);
    check("frame_period", 32'(cyc), 32'd60);
    check("frame_one_clk", 32'(frame_o), 32'd1);
    @(posedge clk_i); #1;
    check("frame_pulse_ends", 32'(frame_o), 32'd0);

    // MD 6-button on port 2 with X held
    mode1 = PAD_FLOAT; held1 = '0;
    mode2 = PAD_MD6;   held2 = 12'h400;
    push_exp(12'hFFF, 12'hBFF, 1'b0, 1'b1);
    check_frame("md6_x", cyc);

    // X released
    held2 = '0;
    push_exp(12'hFFF, 12'hFFF, 1'b0, 1'b1);
    check_frame("md6_rel", cyc);

    // SMS button 1 on port 1, 6-button Mode+Start on port 2
    mode1 = PAD_SMS; held1 = 12'h010;
    held2 = 12'h880;
    push_exp(12'hFEF, 12'h77F, 1'b0, 1'b1);
    check_frame("sms_md6", cyc);

    // MD 3-button with B, C and Up on port 1
    mode1 = PAD_MD3; held1 = 12'h031;
    mode2 = PAD_FLOAT; held2 = '0;
    push_exp(12'hFCE, 12'hFFF, 1'b0, 1'b0);
    check_frame("md3_bcu", cyc);

    // Reset asserted during ST3 (second select fall of the frame)
    held1 = 12'h048;
    falls = 0;
    prev_sel = select_o;
    for (int i = 0; i < 300 && falls < 2; i++) begin
      @(posedge clk_i);
      #1;
      if (prev_sel && !select_o) falls++;
      prev_sel = select_o;
    end
    check("st3_reached", 32'(falls), 32'd2);
    #2;
    check("pre_rst_select", 32'(select_o), 32'd0);
    check("pre_rst_joy1",   32'(joy1_o),   32'hFCE);
    res_n_i = 1'b0;
    #1;
    check("async_rst_select", 32'(select_o), 32'd1);
    check("async_rst_joy1",   32'(joy1_o),   32'hFFF);
    check("async_rst_joy2",   32'(joy2_o),   32'hFFF);
    check("async_rst_six1",   32'(six1_o),   32'd0);
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    res_n_i = 1'b1;
    push_exp(12'hFB7, 12'hFFF, 1'b0, 1'b0);
    check_frame("after_rst", cyc);
    check("after_rst_latency", 32'(cyc), 32'd28);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
